bht_update_ctrl: RTL

//  Read/update controller for the 16-entry 2-bit branch history table (BHT) register file.
//  - Read side: serves prediction lookups from the table outputs.
//  - Write side: queues branch resolutions and runs a read-modify-write per resolution.
//  - Drives the table's shared write data and one-hot write enables.

---
 rtl/bpu_pkg.sv | 32 +++
 rtl/bpu_res_fifo.sv | 49 ++++
 rtl/bht_update_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// Shared types, counter encodings and the saturating-counter step for the branch predictor.
package bpu_pkg;

    localparam int NUM_ENTRIES = 16;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 2;

    localparam logic [CNT_W-1:0] CNT_SNT = 2'b00;
    localparam logic [CNT_W-1:0] CNT_WNT = 2'b01;
    localparam logic [CNT_W-1:0] CNT_WT  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ST  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } upd_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } res_t;

    function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 1'b1;
        end else begin
            return (cnt == CNT_SNT) ? CNT_SNT : cnt - 1'b1;
        end
    endfunction

endpackage

// File: rtl/bpu_res_fifo.sv
// Synchronous FIFO holding queued branch resolutions; DEPTH must be a power of two.
module bpu_res_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Requests that cannot be honoured are ignored, so callers may hold push while full.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// Read/update controller for the 16-entry 2-bit BHT: registered lookups plus a queued
// read-modify-write per branch resolution. Optional counters under BPU_STATS_EN.
module bht_update_ctrl
    import bpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_req,
    input  logic [3:0]  pred_idx,
    output logic        pred_valid,
    output logic        pred_taken,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [3:0]  res_idx,
    input  logic        res_taken,
    input  logic [31:0] cnt_in,
    output logic [1:0]  reg_inp,
    output logic [15:0] en,
    output logic        mispredict,
    output logic [15:0] stat_updates,
    output logic [15:0] stat_mispred
);
    upd_state_t       state;
    upd_state_t       state_nxt;
    res_t             head;
    res_t             cur;
    logic             full;
    logic             empty;
    logic             pop;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] nxt_q;
    logic             mis_q;

    // Resolution handshake: a transfer happens on a rising edge where res_valid && res_ready;
    // res_ready depends only on queue occupancy, never on res_valid.
    assign res_ready = !full;

    bpu_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(res_t))
    ) u_res_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (res_valid),
        .pop   (pop),
        .wdata ({res_idx, res_taken}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign cur_cnt = cnt_in[{cur.idx, 1'b0} +: CNT_W];

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        en         = '0;
        reg_inp    = CNT_SNT;
        mispredict = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = RD;
                end
            end
            RD: state_nxt = WR;
            WR: begin
                en[cur.idx] = 1'b1;
                reg_inp     = nxt_q;
                mispredict  = mis_q;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cur   <= '0;
            nxt_q <= CNT_SNT;
            mis_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) cur <= head;
            if (state == RD) begin
                nxt_q <= sat_next(cur_cnt, cur.taken);
                mis_q <= (cur_cnt[1] != cur.taken);
            end
        end
    end

    // A write landing this cycle is not yet visible on cnt_in, so forward its MSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            pred_valid <= pred_req;
            pred_taken <= en[pred_idx] ? reg_inp[1] : cnt_in[{pred_idx, 1'b1}];
        end
    end

`ifdef BPU_STATS_EN
    logic [15:0] upd_cnt_q;
    logic [15:0] mis_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (state == WR && upd_cnt_q != 16'hFFFF) upd_cnt_q <= upd_cnt_q + 1'b1;
            if (mispredict && mis_cnt_q != 16'hFFFF)  mis_cnt_q <= mis_cnt_q + 1'b1;
        end
    end

    assign stat_updates = upd_cnt_q;
    assign stat_mispred = mis_cnt_q;
`else
    assign stat_updates = '0;
    assign stat_mispred = '0;
`endif

endmodule
